// File: rtl/pong_engine.sv
// Pong game engine: paddles, ball motion, collisions, scoring and serve/play/game-over sequencing.
// Everything advances only on in_frame_tick; all outputs are registers.
module pong_engine #(
   parameter int unsigned BAR_LENGTH   = 180,
   parameter int unsigned BAR_WIDTH    = 20,
   parameter int unsigned BALL_SIZE    = 20,
   parameter int unsigned BAR_SPEED    = 4,
   parameter int unsigned BALL_SPEED   = 2,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned MAX_SCORE    = 9
) (
   input  logic       in_clock,
   input  logic       in_reset,
   input  logic       in_frame_tick,
   input  logic       in_left_up,
   input  logic       in_left_down,
   input  logic       in_right_up,
   input  logic       in_right_down,
   output logic [8:0] out_left_bar_y,
   output logic [8:0] out_right_bar_y,
   output logic [9:0] out_ball_x,
   output logic [8:0] out_ball_y,
   output logic [3:0] out_score_left,
   output logic [3:0] out_score_right,
   output logic [1:0] out_state
);

   // Playfield geometry (640x480 screen)
   localparam int unsigned AW       = 11;
   localparam int unsigned CNT_W    = $clog2(SERVE_FRAMES + 1);
   localparam int unsigned BAR_MAX  = 480 - BAR_LENGTH;
   localparam int unsigned BAR_Y0   = (480 - BAR_LENGTH) / 2;
   localparam int unsigned X_MAX    = 640 - BALL_SIZE;
   localparam int unsigned Y_MAX    = 480 - BALL_SIZE;
   localparam int unsigned X_RIGHT  = 640 - BAR_WIDTH - BALL_SIZE;
   localparam int unsigned BALL_X0  = (640 - BALL_SIZE) / 2;
   localparam int unsigned BALL_Y0  = (480 - BALL_SIZE) / 2;

   typedef enum logic [1:0] {
      ST_SERVE    = 2'd0,
      ST_PLAY     = 2'd1,
      ST_GAMEOVER = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   serve_cnt;
   logic               dir_right;
   logic               dir_down;

   logic [AW-1:0]      bx, by, lbw, rbw;
   logic [AW-1:0]      nx, ny;
   logic               n_right, n_down;
   logic               ov_left, ov_right;
   logic               left_point, right_point;
   logic [8:0]         next_lb, next_rb;

   assign out_state = state_q;

   // Clamped paddle step; widened so the clamps never wrap
   function automatic logic [8:0] bar_step(input logic [8:0] y, input logic up, input logic dn);
      logic [AW-1:0] yw;
      yw = AW'(y);
      if (up && !dn)
         yw = (yw > AW'(BAR_SPEED)) ? yw - AW'(BAR_SPEED) : '0;
      else if (dn && !up)
         yw = (yw + AW'(BAR_SPEED) < AW'(BAR_MAX)) ? yw + AW'(BAR_SPEED) : AW'(BAR_MAX);
      return 9'(yw);
   endfunction

   // Next paddle/ball positions and collision outcome from pre-tick values
   always_comb begin
      bx          = AW'(out_ball_x);
      by          = AW'(out_ball_y);
      lbw         = AW'(out_left_bar_y);
      rbw         = AW'(out_right_bar_y);
      next_lb     = bar_step(out_left_bar_y, in_left_up, in_left_down);
      next_rb     = bar_step(out_right_bar_y, in_right_up, in_right_down);
      ov_left     = (by + AW'(BALL_SIZE) > lbw) && (by < lbw + AW'(BAR_LENGTH));
      ov_right    = (by + AW'(BALL_SIZE) > rbw) && (by < rbw + AW'(BAR_LENGTH));
      nx          = bx;
      ny          = by;
      n_right     = dir_right;
      n_down      = dir_down;
      left_point  = 1'b0;
      right_point = 1'b0;

      if (dir_down) begin
         if (by + AW'(BALL_SPEED) >= AW'(Y_MAX)) begin
            ny     = AW'(Y_MAX);
            n_down = 1'b0;
         end else begin
            ny = by + AW'(BALL_SPEED);
         end
      end else begin
         if (by <= AW'(BALL_SPEED)) begin
            ny     = '0;
            n_down = 1'b1;
         end else begin
            ny = by - AW'(BALL_SPEED);
         end
      end

      if (!dir_right) begin
         if (bx > AW'(BAR_WIDTH) && bx - AW'(BALL_SPEED) <= AW'(BAR_WIDTH) && ov_left) begin
            nx      = AW'(BAR_WIDTH);
            n_right = 1'b1;
         end else if (bx < AW'(BALL_SPEED)) begin
            right_point = 1'b1;
         end else begin
            nx = bx - AW'(BALL_SPEED);
         end
      end else begin
         if (bx < AW'(X_RIGHT) && bx + AW'(BALL_SPEED) >= AW'(X_RIGHT) && ov_right) begin
            nx      = AW'(X_RIGHT);
            n_right = 1'b0;
         end else if (bx + AW'(BALL_SPEED) > AW'(X_MAX)) begin
            left_point = 1'b1;
         end else begin
            nx = bx + AW'(BALL_SPEED);
         end
      end
   end

   // Game state machine and registered outputs, advanced once per frame tick
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         state_q         <= ST_SERVE;
         serve_cnt       <= '0;
         dir_right       <= 1'b1;
         dir_down        <= 1'b1;
         out_left_bar_y  <= 9'(BAR_Y0);
         out_right_bar_y <= 9'(BAR_Y0);
         out_ball_x      <= 10'(BALL_X0);
         out_ball_y      <= 9'(BALL_Y0);
         out_score_left  <= '0;
         out_score_right <= '0;
      end else if (in_frame_tick) begin
         case (state_q)
            ST_SERVE: begin
               out_left_bar_y  <= next_lb;
               out_right_bar_y <= next_rb;
               if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                  serve_cnt <= '0;
                  state_q   <= ST_PLAY;
               end else begin
                  serve_cnt <= serve_cnt + CNT_W'(1);
               end
            end
            ST_PLAY: begin
               out_left_bar_y  <= next_lb;
               out_right_bar_y <= next_rb;
               dir_down        <= n_down;
               if (left_point || right_point) begin
                  out_ball_x <= 10'(BALL_X0);
                  out_ball_y <= 9'(BALL_Y0);
                  serve_cnt  <= '0;
                  // Serve goes toward the player who just conceded
                  dir_right  <= left_point;
                  if (left_point) begin
                     out_score_left <= out_score_left + 4'd1;
                     state_q <= (out_score_left == 4'(MAX_SCORE - 1)) ? ST_GAMEOVER : ST_SERVE;
                  end else begin
                     out_score_right <= out_score_right + 4'd1;
                     state_q <= (out_score_right == 4'(MAX_SCORE - 1)) ? ST_GAMEOVER : ST_SERVE;
                  end
               end else begin
                  out_ball_x <= 10'(nx);
                  out_ball_y <= 9'(ny);
                  dir_right  <= n_right;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
